mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single unified RAM port between the pipeline's instruction fetch (i-side) and memory stage (d-side). Sits between the datapath's fetch/memory stages and the RAM model. Gives the d-side priority so in-flight loads/stores drain before fetch, with a bounded-starvation counter guaranteeing forward progress for fetch. Also detects RAM errors and stuck accesses.

## Interface
- MAX_DSTREAK, 4: max consecutive d-grants while iREN is pending before i-side is forced; range 1..15.
- TIMEOUT, 255: cycles a grant may wait for ACCESS before abort; range 1..255.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request, held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly the completing cycle of an i-access.
- iload  out  32  instruction data (= ramload).
- dREN, dWEN  in  1 each  data read / write request, held until dwait low; dWEN wins if both high.
- daddr, dstore  in  32 each  data address / write data.
- dwait  out  1  low for exactly the completing cycle of a d-access.
- dload  out  32  load data (= ramload).
- ramREN, ramWEN  out  1 each  RAM read / write strobe.
- ramaddr, ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- mem_err  out  1  sticky: a grant ended in ERROR or timeout.

## Operation
- States: IDLE, GRANT_I, GRANT_D. Registered state; RAM outputs decoded from state (Moore), waits use state and ramstate.
- IDLE: dREN|dWEN and not (dstreak==MAX_DSTREAK and iREN) -> GRANT_D; else iREN -> GRANT_I; else stay.
- GRANT_D: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. GRANT_I: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0. IDLE: strobes 0, ramaddr=0, ramstore=0.
- Completion: in GRANT_x with ramstate==ACCESS -> xwait=0 that cycle; next state IDLE.
- ramstate==ERROR in a grant -> waits stay high, mem_err<=1, next IDLE.
- Timeout: tcnt (8 bit) clears on grant entry, increments each grant cycle without ACCESS/ERROR; tcnt==TIMEOUT-1 and still no ACCESS -> mem_err<=1, next IDLE.
- Requester drops its request mid-grant -> strobes drop the same cycle (decode gated by request); next IDLE, no completion, no error.
- dstreak (4 bit): on GRANT_D completion +1 if iREN high, else 0; cleared on GRANT_I completion; saturates at MAX_DSTREAK.
- iwait=1 and dwait=1 in every other case, including when not requesting.
- Address/data not latched: requesters hold them stable while waiting.

## Timing
- Reset: state IDLE, dstreak=0, tcnt=0, mem_err=0; outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=ramload.
- RST mid-grant: strobes drop asynchronously; the access is lost, requester retries.
- Latency: request seen in IDLE at cycle n -> strobes at n+1; ACCESS at n+1 -> wait low at n+1; IDLE at n+2. Min 2 cycles per access; back-to-back throughput one access per 2 cycles + RAM latency.
- Simultaneous iREN and dREN in IDLE: d-side wins unless streak limit reached.
- Fetch starvation bound: at most MAX_DSTREAK d-accesses between two i-accesses while iREN is held.
- mem_err clears only on RST.

## Test plan
- Reset: RST=1 mid-grant -> ramREN=ramWEN=0 immediately, iwait=dwait=1, mem_err=0.
- Single fetch: iREN=1, iaddr=0x40, ramstate ACCESS on first grant cycle -> ramREN=1, ramaddr=0x40 at cycle 1, iwait=0 and iload=ramload at cycle 1, IDLE at cycle 2.
- Conflict: iREN=dWEN=1 in IDLE, daddr=0x100, dstore=0xDEADBEEF -> GRANT_D first, ramWEN=1 with those values; i-access follows after IDLE.
- Starvation: iREN held, dREN held continuously, MAX_DSTREAK=4 -> exactly 4 d-completions, then one i-completion, then d resumes.
- Latency/error: ramstate BUSY 3 cycles then ACCESS -> dwait low only on cycle 4 of grant; ERROR instead -> dwait stays 1, mem_err=1 next cycle, sticky.
- Timeout/abort: ramstate BUSY forever, TIMEOUT=8 -> IDLE after 8 grant cycles, mem_err=1; separately drop dREN mid-grant -> strobes drop same cycle, mem_err stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter between instruction fetch (i-side) and memory stage (d-side).
// D-side has priority; a streak counter forces a fetch grant so fetch cannot starve.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] MAXS = 4'(MAX_DSTREAK);
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [3:0] r_dstreak;
    logic [7:0] r_tcnt;
    logic       r_mem_err;

    logic [1:0] w_next;
    logic [3:0] w_dstreak_nxt;
    logic [7:0] w_tcnt_nxt;
    logic       w_err_set;
    logic       w_dreq;
    logic       w_req;
    logic       w_i_done;
    logic       w_d_done;

    assign w_dreq   = dREN | dWEN;
    assign w_i_done = (r_state == GRANT_I) && iREN   && (ramstate == RAM_ACCESS);
    assign w_d_done = (r_state == GRANT_D) && w_dreq && (ramstate == RAM_ACCESS);

    assign iwait   = ~w_i_done;
    assign dwait   = ~w_d_done;
    assign iload   = ramload;
    assign dload   = ramload;
    assign mem_err = r_mem_err;

    // Strobes are gated by the live request so a withdrawn request releases the RAM at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            GRANT_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
            end
            GRANT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_dstreak_nxt = r_dstreak;
        w_tcnt_nxt    = r_tcnt;
        w_err_set     = 1'b0;
        w_req         = (r_state == GRANT_I) ? iREN : w_dreq;
        case (r_state)
            IDLE: begin
                w_tcnt_nxt = '0;
                if (w_dreq && !((r_dstreak == MAXS) && iREN))
                    w_next = GRANT_D;
                else if (iREN)
                    w_next = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (!w_req) begin
                    w_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    w_next = IDLE;
                    if (r_state == GRANT_I)
                        w_dstreak_nxt = '0;
                    else if (!iREN)
                        w_dstreak_nxt = '0;
                    else if (r_dstreak != MAXS)
                        w_dstreak_nxt = r_dstreak + 4'd1;
                end else if (ramstate == RAM_ERROR) begin
                    w_next    = IDLE;
                    w_err_set = 1'b1;
                end else if (r_tcnt == TLIM) begin
                    w_next    = IDLE;
                    w_err_set = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
            r_tcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dstreak <= w_dstreak_nxt;
            r_tcnt    <= w_tcnt_nxt;
            if (w_err_set)
                r_mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: completions are checked against a scoreboard queue,
// strobes/waits/error flag checked inline at each step.
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK, RST;
    logic        iREN, iwait;
    logic [31:0] iaddr, iload;
    logic        dREN, dWEN, dwait;
    logic [31:0] daddr, dstore, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // side: 0 = fetch, 1 = data; data is store value for writes, load value otherwise
    typedef struct {
        logic        side;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic push(input logic side, input logic [31:0] addr, input logic wen,
                        input logic [31:0] data);
        exp_t e;
        e.side = side; e.addr = addr; e.wen = wen; e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Completion monitor: any low wait must match the oldest expected access.
    always @(negedge CLK) begin
        if (!RST && (!iwait || !dwait)) begin
            exp_t e;
            chk("one_wait_low", {31'b0, (!iwait && !dwait)}, 32'd0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_side", {31'b0, !dwait}, {31'b0, e.side});
                chk("sb_addr", ramaddr, e.addr);
                chk("sb_wen", {31'b0, ramWEN}, {31'b0, e.wen});
                if (e.wen)
                    chk("sb_store", ramstore, e.data);
                else
                    chk("sb_load", e.side ? dload : iload, e.data);
            end
        end
    end

    initial begin
        RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 32'h0; ramstate = FREE;
        #12;
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
        RST = 1'b0;

        // single fetch, RAM answers on first grant cycle
        tick();
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h1111_2222;
        push(1'b0, 32'h40, 1'b0, 32'h1111_2222);
        settle();
        chk("f_idle_ramREN", {31'b0, ramREN}, 32'd0);
        tick(); settle();
        chk("f_g_ramREN", {31'b0, ramREN}, 32'd1);
        chk("f_g_ramaddr", ramaddr, 32'h40);
        chk("f_g_iwait", {31'b0, iwait}, 32'd0);
        chk("f_g_iload", iload, 32'h1111_2222);
        tick();
        iREN = 0;
        settle();
        chk("f_idle2_ramREN", {31'b0, ramREN}, 32'd0);
        chk("f_idle2_iwait", {31'b0, iwait}, 32'd1);

        // conflict: write wins, fetch follows
        tick();
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramload = 32'h3333_4444;
        push(1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF);
        push(1'b0, 32'h80, 1'b0, 32'h3333_4444);
        tick(); settle();
        chk("c_d_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("c_d_ramREN", {31'b0, ramREN}, 32'd0);
        chk("c_d_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("c_d_iwait", {31'b0, iwait}, 32'd1);
        tick();
        dWEN = 0;
        settle();
        chk("c_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
        tick(); settle();
        chk("c_i_ramaddr", ramaddr, 32'h80);
        chk("c_i_iwait", {31'b0, iwait}, 32'd0);
        tick();
        iREN = 0;

        // starvation: both held, 4 d-completions then one fetch then d again
        tick();
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300; ramload = 32'h5555_6666;
        for (int k = 0; k < 4; k++) push(1'b1, 32'h300, 1'b0, 32'h5555_6666);
        push(1'b0, 32'h200, 1'b0, 32'h5555_6666);
        push(1'b1, 32'h300, 1'b0, 32'h5555_6666);
        for (int k = 0; k < 9; k++) tick();
        settle();
        chk("s_forced_iwait", {31'b0, iwait}, 32'd0);
        chk("s_forced_ramaddr", ramaddr, 32'h200);
        tick(); tick(); settle();
        chk("s_resume_dwait", {31'b0, dwait}, 32'd0);
        tick();
        iREN = 0; dREN = 0;

        // latency: BUSY for 3 grant cycles, ACCESS on the 4th
        tick();
        dREN = 1; daddr = 32'h44; ramstate = BUSY; ramload = 32'h7777_8888;
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("l_busy_dwait", {31'b0, dwait}, 32'd1);
            chk("l_busy_ramREN", {31'b0, ramREN}, 32'd1);
        end
        tick();
        ramstate = ACCESS;
        push(1'b1, 32'h44, 1'b0, 32'h7777_8888);
        settle();
        chk("l_done_dwait", {31'b0, dwait}, 32'd0);
        tick();
        dREN = 0; ramstate = FREE;
        settle();
        chk("l_mem_err", {31'b0, mem_err}, 32'd0);

        // abort: request withdrawn mid-grant
        tick();
        dREN = 1; daddr = 32'h60; ramstate = BUSY;
        tick(); settle();
        chk("a_g_ramREN", {31'b0, ramREN}, 32'd1);
        tick();
        dREN = 0;
        settle();
        chk("a_drop_ramREN", {31'b0, ramREN}, 32'd0);
        chk("a_drop_dwait", {31'b0, dwait}, 32'd1);
        tick(); settle();
        chk("a_mem_err", {31'b0, mem_err}, 32'd0);

        // timeout: BUSY forever, grant lasts exactly 8 cycles
        tick();
        dWEN = 1; daddr = 32'h70; dstore = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            tick(); settle();
            chk("t_grant_ramWEN", {31'b0, ramWEN}, 32'd1);
        end
        chk("t_pre_mem_err", {31'b0, mem_err}, 32'd0);
        tick();
        settle();
        chk("t_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("t_mem_err", {31'b0, mem_err}, 32'd1);
        dWEN = 0;

        // reset mid-grant: strobes drop asynchronously, mem_err clears
        tick();
        dREN = 1; daddr = 32'h90;
        tick(); settle();
        chk("r_g_ramREN", {31'b0, ramREN}, 32'd1);
        RST = 1'b1;
        settle();
        chk("r_ramREN", {31'b0, ramREN}, 32'd0);
        chk("r_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("r_dwait", {31'b0, dwait}, 32'd1);
        chk("r_iwait", {31'b0, iwait}, 32'd1);
        chk("r_mem_err", {31'b0, mem_err}, 32'd0);
        dREN = 0;
        #4;
        RST = 1'b0;

        // RAM error: no completion, sticky mem_err
        tick();
        dREN = 1; daddr = 32'h48; ramstate = BUSY;
        tick();
        ramstate = ERROR;
        settle();
        chk("e_dwait", {31'b0, dwait}, 32'd1);
        chk("e_pre_mem_err", {31'b0, mem_err}, 32'd0);
        tick();
        dREN = 0; ramstate = FREE;
        settle();
        chk("e_mem_err", {31'b0, mem_err}, 32'd1);
        tick(); tick(); settle();
        chk("e_sticky", {31'b0, mem_err}, 32'd1);

        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
